// File: rtl/iomem_uart_master.sv
// Byte-stream to iomem bridge: decodes read/write frames arriving from the UART,
// runs one iomem transaction per frame and streams the result bytes back.
module iomem_uart_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic [2:0]  fsm_state
);

    // Handshakes: a byte moves on in/out only on a cycle where valid && ready are
    // both high at the clock edge; the producer holds data stable until then.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        STRB  = 3'd2,
        WDATA = 3'd3,
        BUS   = 3'd4,
        RESP  = 3'd5
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] RSP_ACK   = 8'h4B;
    localparam logic [7:0] RSP_BAD   = 8'h3F;
    localparam logic [7:0] RSP_TMO   = 8'h54;

    state_t        state, state_n;
    logic [1:0]    idx, idx_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          is_write, is_write_n;
    logic [23:0]   resp_buf, resp_buf_n;
    logic [1:0]    resp_left, resp_left_n;

    logic          in_ready_n;
    logic [7:0]    out_data_n;
    logic          out_valid_n;
    logic          iomem_valid_n;
    logic [3:0]    wstrb_n;
    logic [31:0]   addr_n;
    logic [31:0]   wdata_n;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign fsm_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            tcnt        <= '0;
            is_write    <= 1'b0;
            resp_buf    <= '0;
            resp_left   <= '0;
            in_ready    <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            iomem_valid <= 1'b0;
            iomem_wstrb <= '0;
            iomem_addr  <= '0;
            iomem_wdata <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            tcnt        <= tcnt_n;
            is_write    <= is_write_n;
            resp_buf    <= resp_buf_n;
            resp_left   <= resp_left_n;
            in_ready    <= in_ready_n;
            out_data    <= out_data_n;
            out_valid   <= out_valid_n;
            iomem_valid <= iomem_valid_n;
            iomem_wstrb <= wstrb_n;
            iomem_addr  <= addr_n;
            iomem_wdata <= wdata_n;
        end
    end

    always_comb begin
        state_n     = state;
        idx_n       = idx;
        tcnt_n      = tcnt;
        is_write_n  = is_write;
        resp_buf_n  = resp_buf;
        resp_left_n = resp_left;
        out_data_n  = out_data;
        out_valid_n = out_valid;
        wstrb_n     = iomem_wstrb;
        addr_n      = iomem_addr;
        wdata_n     = iomem_wdata;

        case (state)
            IDLE: begin
                if (in_xfer) begin
                    idx_n = '0;
                    if (in_data == CMD_READ) begin
                        state_n    = ADDR;
                        is_write_n = 1'b0;
                        wstrb_n    = 4'h0;
                    end else if (in_data == CMD_WRITE) begin
                        state_n    = ADDR;
                        is_write_n = 1'b1;
                    end else begin
                        state_n     = RESP;
                        out_valid_n = 1'b1;
                        out_data_n  = RSP_BAD;
                        resp_left_n = 2'd0;
                    end
                end
            end
            ADDR: begin
                if (in_xfer) begin
                    addr_n = {iomem_addr[23:0], in_data};
                    idx_n  = idx + 2'd1;
                    if (idx == 2'd3) begin
                        state_n = is_write ? STRB : BUS;
                    end
                end
            end
            STRB: begin
                if (in_xfer) begin
                    // Upper strobe nibble is don't-care; zero strobes become a bus read.
                    wstrb_n = in_data[3:0];
                    state_n = WDATA;
                end
            end
            WDATA: begin
                if (in_xfer) begin
                    wdata_n = {iomem_wdata[23:0], in_data};
                    idx_n   = idx + 2'd1;
                    if (idx == 2'd3) begin
                        state_n = BUS;
                    end
                end
            end
            BUS: begin
                // Ready on the terminal-count cycle still wins over the timeout.
                if (iomem_ready) begin
                    state_n     = RESP;
                    tcnt_n      = '0;
                    out_valid_n = 1'b1;
                    if (is_write) begin
                        out_data_n  = RSP_ACK;
                        resp_left_n = 2'd0;
                    end else begin
                        out_data_n  = iomem_rdata[31:24];
                        resp_buf_n  = iomem_rdata[23:0];
                        resp_left_n = 2'd3;
                    end
                end else if (tcnt == TC_LAST) begin
                    state_n     = RESP;
                    tcnt_n      = '0;
                    out_valid_n = 1'b1;
                    out_data_n  = RSP_TMO;
                    resp_left_n = 2'd0;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            RESP: begin
                if (out_xfer) begin
                    if (resp_left == 2'd0) begin
                        out_valid_n = 1'b0;
                        state_n     = IDLE;
                    end else begin
                        out_data_n  = resp_buf[23:16];
                        resp_buf_n  = {resp_buf[15:0], 8'h00};
                        resp_left_n = resp_left - 2'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        in_ready_n    = (state_n == IDLE) || (state_n == ADDR) ||
                        (state_n == STRB) || (state_n == WDATA);
        iomem_valid_n = (state_n == BUS);
    end

endmodule

// File: tb/tb_iomem_uart_master.sv
// Directed bench for iomem_uart_master: frame drivers feed the UART side, a bus
// responder and an output monitor check the DUT against expected queues.
module tb_iomem_uart_master;

    localparam int TIMEOUT = 1024;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic [2:0]  fsm_state;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        chk_wdata;
        logic        respond;
        logic [31:0] rdata;
        logic [10:0] delay;
    } bus_t;

    logic [7:0] exp_q[$];
    bus_t       bus_q[$];

    int n_cmp = 0;
    int n_err = 0;

    iomem_uart_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .iomem_valid(iomem_valid),
        .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_rdata(iomem_rdata),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},    {31'd0, in_ready},    32'd0);
        check({tag, "_out_valid"},   {31'd0, out_valid},   32'd0);
        check({tag, "_out_data"},    {24'd0, out_data},    32'd0);
        check({tag, "_iomem_valid"}, {31'd0, iomem_valid}, 32'd0);
        check({tag, "_wstrb"},       {28'd0, iomem_wstrb}, 32'd0);
        check({tag, "_addr"},        iomem_addr,           32'd0);
        check({tag, "_wdata"},       iomem_wdata,          32'd0);
        check({tag, "_state"},       {29'd0, fsm_state},   32'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        int waited;
        bit done;
        waited = 0;
        done = 0;
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                waited++;
                if (waited > 3000) begin
                    check("in_ready_wait", 32'd0, 32'd1);
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] rd,
                           input logic respond, input int dly);
        bus_t r;
        r.addr      = a;
        r.wdata     = '0;
        r.wstrb     = 4'h0;
        r.chk_wdata = 1'b0;
        r.respond   = respond;
        r.rdata     = rd;
        r.delay     = 11'(dly);
        bus_q.push_back(r);
        if (respond) begin
            exp_q.push_back(rd[31:24]);
            exp_q.push_back(rd[23:16]);
            exp_q.push_back(rd[15:8]);
            exp_q.push_back(rd[7:0]);
        end else begin
            exp_q.push_back(8'h54);
        end
        send_byte(8'h52);
        send_byte(a[31:24]);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [7:0] s, input logic [31:0] d,
                            input logic respond, input int dly);
        bus_t r;
        r.addr      = a;
        r.wdata     = d;
        r.wstrb     = s[3:0];
        r.chk_wdata = (s[3:0] != 4'h0);
        r.respond   = respond;
        r.rdata     = 32'h0BAD_F00D;
        r.delay     = 11'(dly);
        bus_q.push_back(r);
        exp_q.push_back(respond ? 8'h4B : 8'h54);
        send_byte(8'h57);
        send_byte(a[31:24]);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_byte(s);
        send_byte(d[31:24]);
        send_byte(d[23:16]);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
    endtask

    task automatic do_invalid(input logic [7:0] b);
        exp_q.push_back(8'h3F);
        send_byte(b);
    endtask

    task automatic wait_done();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || bus_q.size() != 0 || out_valid || iomem_valid) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("drain_in_time", {31'd0, (w < 5000)}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- bus responder + bus scoreboard ----------------
    initial begin
        bus_t rec;
        int dur;
        bit done;
        bit aborted;
        iomem_ready = 1'b0;
        iomem_rdata = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            if (!reset && iomem_valid) begin
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", 32'd1, 32'd0);
                    while (iomem_valid && !reset) @(negedge clk);
                end else begin
                    rec = bus_q.pop_front();
                    dur = 0;
                    done = 0;
                    aborted = 0;
                    while (!done) begin
                        check("bus_addr", iomem_addr, rec.addr);
                        check("bus_wstrb", {28'd0, iomem_wstrb}, {28'd0, rec.wstrb});
                        if (rec.chk_wdata) check("bus_wdata", iomem_wdata, rec.wdata);
                        dur++;
                        if (rec.respond && dur == int'(rec.delay) + 1) begin
                            iomem_ready = 1'b1;
                            iomem_rdata = rec.rdata;
                        end
                        @(negedge clk);
                        if (iomem_ready) begin
                            iomem_ready = 1'b0;
                            iomem_rdata = 32'hDEAD_BEEF;
                        end
                        if (reset) begin
                            aborted = 1;
                            done = 1;
                        end else if (!iomem_valid) begin
                            done = 1;
                        end else if (dur > 3000) begin
                            check("bus_valid_stuck", 32'd1, 32'd0);
                            done = 1;
                        end
                    end
                    if (!aborted) begin
                        check("bus_valid_cycles", dur,
                              rec.respond ? int'(rec.delay) + 1 : TIMEOUT);
                    end
                end
            end
        end
    end

    // ---------------- output monitor / response scoreboard ----------------
    initial begin
        logic [7:0] hold_d;
        logic [7:0] exp_b;
        bit hold_v;
        hold_v = 0;
        hold_d = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hold_v = 0;
            end else begin
                if (out_valid) check("in_ready_low_during_resp", {31'd0, in_ready}, 32'd0);
                if (out_valid && !out_ready) begin
                    if (hold_v) check("out_data_held", {24'd0, out_data}, {24'd0, hold_d});
                    hold_v = 1;
                    hold_d = out_data;
                end else if (out_valid && out_ready) begin
                    if (hold_v) check("out_data_held", {24'd0, out_data}, {24'd0, hold_d});
                    hold_v = 0;
                    if (exp_q.size() == 0) begin
                        check("out_unexpected", {24'd0, out_data}, 32'hFFFF_FFFF);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("out_byte", {24'd0, out_data}, {24'd0, exp_b});
                    end
                end else begin
                    hold_v = 0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int w;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // GPIO write, then read it back.
        do_write(32'h0300_0000, 8'h0F, 32'h0000_0003, 1'b1, 2);
        wait_done();
        do_read(32'h0300_0000, 32'h0000_0003, 1'b1, 1);
        wait_done();

        // No responder: timeout, then a normal frame.
        do_read(32'h0500_0000, 32'h0, 1'b0, 0);
        wait_done();
        do_read(32'h0400_0010, 32'hA1B2_C3D4, 1'b1, 0);
        wait_done();

        // Zero strobes act as a bus read but still acknowledge; upper S bits ignored.
        do_write(32'h0400_0004, 8'hF0, 32'h1122_3344, 1'b1, 3);
        wait_done();
        do_write(32'h0400_0008, 8'h35, 32'hCAFE_0001, 1'b1, 0);
        wait_done();

        // Output backpressure on a read response.
        out_ready = 1'b0;
        do_read(32'h0300_0004, 32'h5A6B_7C8D, 1'b1, 1);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("bp_out_valid_seen", {31'd0, out_valid}, 32'd1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done();

        // Invalid command followed back-to-back by a read.
        do_invalid(8'hAA);
        do_read(32'h0400_0020, 32'h0102_0304, 1'b1, 2);
        wait_done();

        // Write timeout, and ready landing on the terminal-count cycle.
        do_write(32'h0600_0000, 8'h0F, 32'hFFFF_FFFF, 1'b0, 0);
        wait_done();
        do_read(32'h0300_0008, 32'h8877_6655, 1'b1, TIMEOUT - 1);
        wait_done();

        // Reset during WDATA.
        send_byte(8'h57);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h0F);
        send_byte(8'h12);
        send_byte(8'h34);
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_wdata");
        @(negedge clk);
        reset = 1'b0;
        do_write(32'h0300_0000, 8'h03, 32'h0000_00A5, 1'b1, 1);
        wait_done();

        // Reset during BUS (responder silent, transaction abandoned).
        begin
            bus_t r;
            r.addr      = 32'h0300_000C;
            r.wdata     = 32'h0000_0077;
            r.wstrb     = 4'hF;
            r.chk_wdata = 1'b1;
            r.respond   = 1'b0;
            r.rdata     = '0;
            r.delay     = '0;
            bus_q.push_back(r);
        end
        send_byte(8'h57);
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h0C);
        send_byte(8'h0F);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h77);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_bus");
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_bus_no_resp", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        do_write(32'h0300_0010, 8'h0F, 32'hDEAD_0042, 1'b1, 0);
        wait_done();

        repeat (5) @(posedge clk);
        check("exp_q_empty", exp_q.size(), 32'd0);
        check("bus_q_empty", bus_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
